dtw_result_packer: RTL and testbench



---
 rtl/dtw_pkg.sv | 30 +++
 rtl/dtw_min2_tracker.sv | 42 ++++
 rtl/dtw_result_packer.sv | 132 +++++++++++++
 tb/tb_dtw_result_packer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared constants for the DTW result packer: FSM encoding, packet layout, magic tag.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dtw_pkg;

  // Packet geometry and header tag
  localparam int          NUMBER_OF_OUTPUT_WORDS = 8;
  localparam logic [15:0] C_MAGIC                = 16'hDA7A;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ACCUM = 2'b01;
  localparam logic [1:0] ST_EMIT  = 2'b10;

  // Word positions inside the result packet
  localparam logic [2:0] W_HDR  = 3'd0;
  localparam logic [2:0] W_MIN1 = 3'd1;
  localparam logic [2:0] W_POS1 = 3'd2;
  localparam logic [2:0] W_MIN2 = 3'd3;
  localparam logic [2:0] W_POS2 = 3'd4;
  localparam logic [2:0] W_COL  = 3'd5;
  localparam logic [2:0] W_CYC  = 3'd6;
  localparam logic [2:0] W_CSUM = 3'd7;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dtw_min2_tracker.sv
// Tracks the smallest and second-smallest score seen, with their positions.
// Latency: 1 cycle from update/clear to the new values on the outputs.
// Backpressure: none; an update is applied on every cycle upd is high.
// Ports: clk/rst (sync active-high), clear, upd + score/pos in; min1/pos1/min2/pos2 out.
module dtw_min2_tracker
  import dtw_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         upd,
  input  logic [W-1:0] score,
  input  logic [W-1:0] pos,
  output logic [W-1:0] min1,
  output logic [W-1:0] pos1,
  output logic [W-1:0] min2,
  output logic [W-1:0] pos2
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      min1 <= '1;
      min2 <= '1;
      pos1 <= '0;
      pos2 <= '0;
    end else if (upd) begin
      // Strict compares: on a tie with min1 the earlier position keeps the top slot
      if (score < min1) begin
        min2 <= min1;
        pos2 <= pos1;
        min1 <= score;
        pos1 <= pos;
      end else if (score < min2) begin
        min2 <= score;
        pos2 <= pos;
      end
    end
  end

endmodule

// File: rtl/dtw_result_packer.sv
// Collects per-column DTW scores for one query and writes an 8-word result packet to the output FIFO.
// Latency: packet emission starts the cycle after the last score is accepted; one word per non-full cycle.
// Backpressure: score_ready low while emitting; dtw_fifo_full stalls emission with word and data held.
// Ports: ACLK/ARESET; score_valid/ready/data/last + query_id in; dtw_fifo_wren/din out, dtw_fifo_full in;
//        busy and packet_count status out.
module dtw_result_packer
  import dtw_pkg::*;
#(
  parameter int          C_S_AXIS_TDATA_WIDTH   = 32,
  parameter int          NUMBER_OF_OUTPUT_WORDS = dtw_pkg::NUMBER_OF_OUTPUT_WORDS,
  parameter logic [15:0] C_MAGIC                = dtw_pkg::C_MAGIC
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            score_valid,
  output logic                            score_ready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] score_data,
  input  logic                            score_last,
  input  logic [15:0]                     query_id,
  output logic                            dtw_fifo_wren,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] dtw_fifo_din,
  input  logic                            dtw_fifo_full,
  output logic                            busy,
  output logic [15:0]                     packet_count
);

  localparam int         DW       = C_S_AXIS_TDATA_WIDTH;
  localparam logic [2:0] LAST_IDX = 3'(NUMBER_OF_OUTPUT_WORDS - 1);

  logic [1:0]    state;
  logic [15:0]   qid;
  logic [DW-1:0] col;
  logic [DW-1:0] cyc;
  logic [2:0]    word_idx;

  logic          accept;
  logic          wr;
  logic          pkt_done;
  logic [DW-1:0] trk_pos;
  logic [DW-1:0] min1, pos1, min2, pos2;
  logic [DW-1:0] hdr, csum;

  assign score_ready   = (state != ST_EMIT);
  assign accept        = score_valid && score_ready;
  assign wr            = (state == ST_EMIT) && !dtw_fifo_full;
  assign pkt_done      = wr && (word_idx == LAST_IDX);
  assign dtw_fifo_wren = wr;
  assign busy          = (state != ST_IDLE);

  // The first score of a query is position 0; col already counts columns accepted so far
  assign trk_pos = (state == ST_IDLE) ? '0 : col;

  dtw_min2_tracker #(.W(DW)) u_tracker (
    .clk   (ACLK),
    .rst   (ARESET),
    .clear (pkt_done),
    .upd   (accept),
    .score (score_data),
    .pos   (trk_pos),
    .min1  (min1),
    .pos1  (pos1),
    .min2  (min2),
    .pos2  (pos2)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= ST_IDLE;
      qid          <= '0;
      col          <= '0;
      cyc          <= '0;
      word_idx     <= '0;
      packet_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            qid   <= query_id;
            col   <= DW'(1);
            cyc   <= DW'(1);
            state <= score_last ? ST_EMIT : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          // cyc measures wall-clock span of the query, so it counts idle cycles too
          cyc <= sat_inc32(cyc);
          if (accept) begin
            col <= sat_inc32(col);
            if (score_last) state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (wr) begin
            if (pkt_done) begin
              state        <= ST_IDLE;
              word_idx     <= '0;
              packet_count <= packet_count + 16'd1;
              qid          <= '0;
              col          <= '0;
              cyc          <= '0;
            end else begin
              word_idx <= word_idx + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign hdr  = {C_MAGIC, qid};
  assign csum = hdr ^ min1 ^ pos1 ^ min2 ^ pos2 ^ col ^ cyc;

  // Fields are frozen during EMIT, so the selected word is stable across full stalls
  always_comb begin
    dtw_fifo_din = '0;
    if (state == ST_EMIT) begin
      case (word_idx)
        W_HDR:   dtw_fifo_din = hdr;
        W_MIN1:  dtw_fifo_din = min1;
        W_POS1:  dtw_fifo_din = pos1;
        W_MIN2:  dtw_fifo_din = min2;
        W_POS2:  dtw_fifo_din = pos2;
        W_COL:   dtw_fifo_din = col;
        W_CYC:   dtw_fifo_din = cyc;
        W_CSUM:  dtw_fifo_din = csum;
        default: dtw_fifo_din = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_result_packer.sv
module tb_dtw_result_packer;

  logic        ACLK;
  logic        ARESET;
  logic        score_valid;
  logic        score_ready;
  logic [31:0] score_data;
  logic        score_last;
  logic [15:0] query_id;
  logic        dtw_fifo_wren;
  logic [31:0] dtw_fifo_din;
  logic        dtw_fifo_full;
  logic        busy;
  logic [15:0] packet_count;

  dtw_result_packer dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .score_valid   (score_valid),
    .score_ready   (score_ready),
    .score_data    (score_data),
    .score_last    (score_last),
    .query_id      (query_id),
    .dtw_fifo_wren (dtw_fifo_wren),
    .dtw_fifo_din  (dtw_fifo_din),
    .dtw_fifo_full (dtw_fifo_full),
    .busy          (busy),
    .packet_count  (packet_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Queue the expected packet; nw < 8 is used for a packet that is cut short by reset
  task automatic push_pkt(input logic [15:0] qid, input logic [31:0] m1, input logic [31:0] p1,
                          input logic [31:0] m2, input logic [31:0] p2, input logic [31:0] col,
                          input logic [31:0] cyc, input int nw);
    logic [31:0] w[8];
    w[0] = {16'hDA7A, qid};
    w[1] = m1; w[2] = p1; w[3] = m2; w[4] = p2; w[5] = col; w[6] = cyc;
    w[7] = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4] ^ w[5] ^ w[6];
    for (int i = 0; i < nw; i++) exp_q.push_back(w[i]);
  endtask

  // Monitor: every real FIFO write is popped against the scoreboard
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (dtw_fifo_full) begin
        n_chk++;
        if (dtw_fifo_wren) begin
          n_fail++;
          $display("FAIL wren_while_full: wren=%b full=%b, expected wren=0", dtw_fifo_wren, dtw_fifo_full);
        end
      end
      if (dtw_fifo_wren && !dtw_fifo_full) begin
        wr_cnt++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got %h, expected no write", dtw_fifo_din);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (dtw_fifo_din !== e) begin
            n_fail++;
            $display("FAIL packet_word %0d: got %h, expected %h", wr_cnt - 1, dtw_fifo_din, e);
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] qid, input logic [31:0] s, input logic last);
    int n;
    score_valid = 1'b1;
    score_data  = s;
    score_last  = last;
    query_id    = qid;
    n = 0;
    while (!score_ready && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    @(posedge ACLK); #1;
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  task automatic wait_writes(input int target);
    int n;
    n = 0;
    do begin
      @(negedge ACLK); #1;
      n++;
    end while (wr_cnt < target && n < 200);
    if (wr_cnt < target) chk("wait_writes_timeout", 32'(wr_cnt), 32'(target));
  endtask

  task automatic wait_done(input string name, input logic [15:0] exp_pc);
    int n;
    n = 0;
    do begin
      @(negedge ACLK); #1;
      n++;
    end while (busy && n < 300);
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_packet_count"}, 32'(packet_count), 32'(exp_pc));
  endtask

  initial begin
    int base;
    int n;
    ARESET        = 1'b1;
    score_valid   = 1'b0;
    score_data    = '0;
    score_last    = 1'b0;
    query_id      = '0;
    dtw_fifo_full = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_ready", 32'(score_ready), 32'd1);
    chk("rst_wren", 32'(dtw_fifo_wren), 32'd0);
    chk("rst_din", dtw_fifo_din, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc", 32'(packet_count), 32'd0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Basic packet: 10,5,7,5 back-to-back
    push_pkt(16'd3, 32'd5, 32'd1, 32'd5, 32'd3, 32'd4, 32'd4, 8);
    send(16'd3, 32'd10, 1'b0);
    send(16'd3, 32'd5, 1'b0);
    send(16'd3, 32'd7, 1'b0);
    send(16'd3, 32'd5, 1'b1);
    wait_done("basic", 16'd1);

    // Single column: ready low for exactly the 8 emit cycles
    push_pkt(16'h00FF, 32'd42, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd1, 8);
    send(16'h00FF, 32'd42, 1'b1);
    n = 0;
    while (!score_ready && n < 100) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("single_ready_low_cycles", 32'(n), 32'd8);
    wait_done("single", 16'd2);

    // Backpressure: full for 5 cycles at word 3, then toggling
    base = wr_cnt;
    push_pkt(16'd3, 32'd5, 32'd1, 32'd5, 32'd3, 32'd4, 32'd4, 8);
    send(16'd3, 32'd10, 1'b0);
    send(16'd3, 32'd5, 1'b0);
    send(16'd3, 32'd7, 1'b0);
    send(16'd3, 32'd5, 1'b1);
    wait_writes(base + 3);
    @(posedge ACLK); #1;
    dtw_fifo_full = 1'b1;
    repeat (5) @(posedge ACLK);
    for (int i = 0; i < 16; i++) begin
      #1 dtw_fifo_full = ~dtw_fifo_full;
      @(posedge ACLK);
    end
    #1 dtw_fifo_full = 1'b0;
    wait_done("backpressure", 16'd3);
    chk("backpressure_write_count", 32'(wr_cnt - base), 32'd8);

    // Gapped input: 9, three idle cycles, 8 last
    push_pkt(16'd7, 32'd8, 32'd1, 32'd9, 32'd0, 32'd2, 32'd5, 8);
    send(16'd7, 32'd9, 1'b0);
    repeat (3) @(posedge ACLK);
    #1;
    send(16'd7, 32'd8, 1'b1);
    wait_done("gapped", 16'd4);

    // Ties: the earlier position wins the top slot
    push_pkt(16'd5, 32'd7, 32'd0, 32'd7, 32'd1, 32'd3, 32'd3, 8);
    send(16'd5, 32'd7, 1'b0);
    send(16'd5, 32'd7, 1'b0);
    send(16'd5, 32'd7, 1'b1);
    wait_done("ties", 16'd5);

    // Reset after word 2 has been written
    base = wr_cnt;
    push_pkt(16'h0011, 32'd2, 32'd1, 32'd4, 32'd0, 32'd2, 32'd2, 3);
    send(16'h0011, 32'd4, 1'b0);
    send(16'h0011, 32'd2, 1'b1);
    wait_writes(base + 3);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("midrst_wren", 32'(dtw_fifo_wren), 32'd0);
    chk("midrst_pc", 32'(packet_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(score_ready), 32'd1);
    ARESET = 1'b0;
    chk("midrst_write_count", 32'(wr_cnt - base), 32'd3);
    @(posedge ACLK); #1;
    push_pkt(16'h0022, 32'd6, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd1, 8);
    send(16'h0022, 32'd6, 1'b1);
    wait_done("after_reset", 16'd1);

    repeat (3) @(posedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
